// File: rtl/stereo_window_feeder.sv
// stereo_window_feeder: buffers L/R rasters into a WIN-row window and sequences one core run per column.
// Define STEREO_FEEDER_BORDER_EN to pad each row with WIN-1 zero results, giving IMG_W results per row.
module stereo_window_feeder #(
  parameter int WIN = 15,
  parameter int DATA_SIZE = 8,
  parameter int IMG_W = 64,
  parameter int MAX_DISP = 64,
  localparam int DISP_BITS = $clog2(MAX_DISP),
  localparam int IMG_W_ARR = $clog2(IMG_W)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             pix_valid,
  output logic                             pix_ready,
  input  logic                             pix_sof,
  input  logic [DATA_SIZE-1:0]             pix_L,
  input  logic [DATA_SIZE-1:0]             pix_R,
  output logic [DATA_SIZE*IMG_W*WIN-1:0]   array_L,
  output logic [DATA_SIZE*IMG_W*WIN-1:0]   array_R,
  output logic [IMG_W_ARR-1:0]             col_index,
  output logic                             start,
  input  logic                             core_done,
  input  logic [DISP_BITS-1:0]             core_disp,
  output logic                             disp_valid,
  output logic [DISP_BITS-1:0]             disp_out,
  output logic [IMG_W_ARR-1:0]             disp_col
);
  localparam int RW = WIN > 1 ? $clog2(WIN) : 1;
  localparam int FW = $clog2(WIN + 1);
  localparam logic [IMG_W_ARR-1:0] LAST_COL = IMG_W_ARR'(IMG_W - 1);
  localparam logic [IMG_W_ARR-1:0] LAST_ISSUE = IMG_W_ARR'(IMG_W - WIN);
`ifdef STEREO_FEEDER_BORDER_EN
  localparam bit BORDER = 1'b1;
`else
  localparam bit BORDER = 1'b0;
`endif
  typedef enum logic [2:0] {FILL, ISSUE, WAIT, EMIT, PAD} state_t;
  state_t state, nxt;
  logic [DATA_SIZE-1:0] mem_l [WIN][IMG_W];
  logic [DATA_SIZE-1:0] mem_r [WIN][IMG_W];
  logic [IMG_W_ARR-1:0] wr_col, col, wcol;
  logic [RW-1:0] wr_row;
  logic [FW-1:0] rows_filled;
  logic [DISP_BITS-1:0] lat;
  logic acc;
  assign acc = pix_valid & pix_ready;
  assign wcol = pix_sof ? '0 : wr_col;
  always_ff @(posedge clk)
    if (rst) state <= FILL;
    else state <= nxt;
  always_ff @(posedge clk)
    if (rst) begin
      rows_filled <= '0;
      wr_col <= '0;
      wr_row <= '0;
      col <= '0;
      lat <= '0;
    end else begin
      if (acc) begin
        if (pix_sof) begin
          rows_filled <= '0;
          wr_col <= IMG_W_ARR'(1);
        end else if (wr_col == LAST_COL) begin
          wr_col <= '0;
          wr_row <= wr_row == RW'(WIN - 1) ? '0 : wr_row + 1'b1;
          rows_filled <= rows_filled == FW'(WIN) ? rows_filled : rows_filled + 1'b1;
        end else wr_col <= wr_col + 1'b1;
      end
      if (state == WAIT && core_done) lat <= core_disp;
      if (state == EMIT || state == PAD)
        col <= ((state == EMIT) ? (col == LAST_ISSUE && !BORDER) : (col == LAST_COL)) ? '0 : col + 1'b1;
    end
  // Line buffer contents carry no reset; only the pointers define what is valid.
  always_ff @(posedge clk)
    if (acc) begin
      mem_l[wr_row][wcol] <= pix_L;
      mem_r[wr_row][wcol] <= pix_R;
    end
  always_comb begin
    nxt = state;
    unique case (state)
      FILL:  nxt = (acc && !pix_sof && wr_col == LAST_COL && rows_filled >= FW'(WIN - 1)) ? ISSUE : FILL;
      ISSUE: nxt = WAIT;
      WAIT:  nxt = core_done ? EMIT : WAIT;
      EMIT:  nxt = col == LAST_ISSUE ? (BORDER ? PAD : FILL) : ISSUE;
      PAD:   nxt = col == LAST_COL ? FILL : PAD;
      default: nxt = FILL;
    endcase
  end
  always_comb begin
    pix_ready = state == FILL;
    start = state == ISSUE;
    disp_valid = state == EMIT || state == PAD;
    disp_out = state == PAD ? '0 : lat;
  end
  assign col_index = col;
  assign disp_col = col;
  // Once full, wr_row points at the oldest row, so logical row r lives at (wr_row + r) mod WIN.
  for (genvar r = 0; r < WIN; r++) begin : g_row
    logic [RW:0] s;
    logic [RW-1:0] p;
    assign s = {1'b0, wr_row} + (RW + 1)'(r);
    assign p = s >= (RW + 1)'(WIN) ? RW'(s - (RW + 1)'(WIN)) : RW'(s);
    for (genvar c = 0; c < IMG_W; c++) begin : g_col
      assign array_L[(r * IMG_W + c) * DATA_SIZE +: DATA_SIZE] = mem_l[p][c];
      assign array_R[(r * IMG_W + c) * DATA_SIZE +: DATA_SIZE] = mem_r[p][c];
    end
  end
endmodule

// File: tb/tb_stereo_window_feeder.sv
// tb_stereo_window_feeder: random and directed streams against a shift-window reference model with a stub core.
module tb_stereo_window_feeder;
  localparam int WIN = 3, DS = 8, IMG_W = 8, MAX_DISP = 8, DB = 3, CW = 3;
  localparam int AW = DS * IMG_W * WIN;
  localparam int NST = IMG_W - WIN + 1;
`ifdef STEREO_FEEDER_BORDER_EN
  localparam int NRES = IMG_W;
`else
  localparam int NRES = NST;
`endif
  logic clk = 0, rst = 1, pix_valid = 0, pix_sof = 0;
  logic [DS-1:0] pix_L = 0, pix_R = 0;
  logic pix_ready, start, disp_valid;
  logic core_done = 0;
  logic [DB-1:0] core_disp = 0, disp_out;
  logic [AW-1:0] array_L, array_R;
  logic [CW-1:0] col_index, disp_col;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;

  stereo_window_feeder #(.WIN(WIN), .DATA_SIZE(DS), .IMG_W(IMG_W), .MAX_DISP(MAX_DISP)) dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_sof(pix_sof),
    .pix_L(pix_L), .pix_R(pix_R), .array_L(array_L), .array_R(array_R), .col_index(col_index),
    .start(start), .core_done(core_done), .core_disp(core_disp), .disp_valid(disp_valid),
    .disp_out(disp_out), .disp_col(disp_col));

  // stub core: done 4 cycles after start, disp = col_index + 2, done held until next start
  int cd_cnt = 0;
  always @(posedge clk)
    if (start) begin
      cd_cnt <= 4;
      core_done <= 0;
      core_disp <= DB'(col_index + 2);
    end else if (cd_cnt > 0) begin
      cd_cnt <= cd_cnt - 1;
      if (cd_cnt == 1) core_done <= 1;
    end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DS-1:0] el(input logic [AW-1:0] a, input int k);
    return a[k*DS +: DS];
  endfunction

  // reference model: last WIN complete rows as a shift window, row 0 oldest
  logic [DS-1:0] wl [WIN][IMG_W], wr [WIN][IMG_W], cl [IMG_W], cr [IMG_W];
  logic [AW-1:0] fl, fr;
  int ccol = 0, nrows = 0;
  bit need_start = 0;
  int sq_col[$], rq_disp[$], rq_col[$], log_disp[$], log_col[$];
  logic [AW-1:0] sq_l[$], sq_r[$];
  int n_starts = 0, n_pulses = 0;

  always @(negedge clk) begin
    if (rst) begin
      sq_col.delete(); sq_l.delete(); sq_r.delete(); rq_disp.delete(); rq_col.delete();
      need_start = 0; ccol = 0; nrows = 0;
    end else begin
      chk("pix_ready", pix_ready, rq_disp.size() == 0);
      if (need_start) begin
        chk("start_latency", start, 1);
        need_start = 0;
      end
      if (start) begin
        n_starts++;
        chk("start_expected", sq_col.size() != 0, 1);
        if (sq_col.size() != 0) begin
          chk("col_index", col_index, sq_col.pop_front());
          chk("array_L", array_L, sq_l.pop_front());
          chk("array_R", array_R, sq_r.pop_front());
        end
      end
      if (disp_valid) begin
        n_pulses++;
        log_disp.push_back(int'(disp_out));
        log_col.push_back(int'(disp_col));
        chk("disp_expected", rq_disp.size() != 0, 1);
        if (rq_disp.size() != 0) begin
          chk("disp_out", disp_out, rq_disp.pop_front());
          chk("disp_col", disp_col, rq_col.pop_front());
        end
      end
      if (pix_valid && pix_ready) begin
        if (pix_sof) begin nrows = 0; ccol = 0; end
        cl[ccol] = pix_L;
        cr[ccol] = pix_R;
        ccol++;
        if (ccol == IMG_W) begin
          ccol = 0;
          nrows++;
          for (int r = 0; r < WIN - 1; r++) begin wl[r] = wl[r+1]; wr[r] = wr[r+1]; end
          wl[WIN-1] = cl;
          wr[WIN-1] = cr;
          if (nrows >= WIN) begin
            for (int r = 0; r < WIN; r++)
              for (int c = 0; c < IMG_W; c++) begin
                fl[(r*IMG_W+c)*DS +: DS] = wl[r][c];
                fr[(r*IMG_W+c)*DS +: DS] = wr[r][c];
              end
            for (int c = 0; c < NST; c++) begin
              sq_col.push_back(c); sq_l.push_back(fl); sq_r.push_back(fr);
            end
            for (int c = 0; c < NRES; c++) begin
              rq_disp.push_back(c < NST ? (c + 2) % MAX_DISP : 0);
              rq_col.push_back(c);
            end
            need_start = 1;
          end
        end
      end
    end
  end

  task automatic send(input logic [DS-1:0] l, input logic [DS-1:0] r, input bit sof, input int gap);
    int n = 0;
    bit a = 0;
    pix_L = l; pix_R = r; pix_sof = sof; pix_valid = 1;
    do begin
      @(negedge clk);
      a = pix_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!a && n < 400);
    chk("send_timeout", a, 1);
    pix_valid = 0;
    pix_sof = 0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic send_row(input int base, input bit sof, input int gap);
    for (int c = 0; c < IMG_W; c++) send(DS'(base + c), DS'(255 - base - c), sof && c == 0, gap);
  endtask

  task automatic drain();
    int n = 0;
    while (rq_disp.size() != 0 && n < 400) begin @(negedge clk); n++; end
    chk("drain_timeout", rq_disp.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_row_results(input int first, input int p0);
    chk("pulse_count", n_pulses - p0, NRES);
    for (int i = 0; i < NRES && first + i < log_disp.size(); i++) begin
      chk("lit_disp", log_disp[first+i], i < NST ? i + 2 : 0);
      chk("lit_col", log_col[first+i], i);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, s0, f0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_pix_ready", pix_ready, 1);
    chk("rst_start", start, 0);
    chk("rst_disp_valid", disp_valid, 0);
    chk("rst_col_index", col_index, 0);
    chk("rst_disp_out", disp_out, 0);
    chk("rst_disp_col", disp_col, 0);
    @(posedge clk); #1;
    // first frame: rows 0..2, pix_L = r*16+c
    p0 = n_pulses; f0 = log_disp.size();
    for (int r = 0; r < WIN; r++) send_row(r * 16, r == 0, 0);
    chk("lit_start", start, 1);
    chk("lit_ready_low", pix_ready, 0);
    chk("lit_a0", el(array_L, 0), 8'h00);
    chk("lit_a9", el(array_L, 9), 8'h11);
    chk("lit_a23", el(array_L, 23), 8'h27);
    chk("lit_r0", el(array_R, 0), 8'hFF);
    drain();
    check_row_results(f0, p0);
    chk("ready_after_row", pix_ready, 1);
    // row 3 overwrites the oldest row
    p0 = n_pulses; f0 = log_disp.size();
    send_row(8'h30, 0, 0);
    chk("lit_row3_start", start, 1);
    chk("lit_row0_old", el(array_L, 0), 8'h10);
    chk("lit_row2_new", el(array_L, 16), 8'h30);
    chk("lit_row2_last", el(array_L, 23), 8'h37);
    drain();
    check_row_results(f0, p0);
    // sof mid-row discards the partial row and restarts the fill
    s0 = n_starts;
    send_row(8'h40, 1, 0);
    for (int c = 0; c < 3; c++) send(DS'(8'h50 + c), 8'h00, 0, 0);
    send_row(8'h60, 1, 0);
    send_row(8'h70, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("sof_no_start", n_starts - s0, 0);
    p0 = n_pulses; f0 = log_disp.size();
    send_row(8'h80, 0, 0);
    chk("sof_start", start, 1);
    chk("sof_row0", el(array_L, 0), 8'h60);
    chk("sof_row1", el(array_L, 8), 8'h70);
    chk("sof_row2", el(array_L, 16), 8'h80);
    drain();
    check_row_results(f0, p0);
    // pix_valid toggling every cycle
    p0 = n_pulses; f0 = log_disp.size();
    for (int r = 0; r < WIN; r++) send_row(r * 16, r == 0, 1);
    drain();
    check_row_results(f0, p0);
    // random pixels, random gaps, occasional random sof
    for (int r = 0; r < 12; r++)
      for (int c = 0; c < IMG_W; c++)
        send(DS'($urandom), DS'($urandom), (r == 0 && c == 0) || $urandom_range(0, 49) == 0,
             $urandom_range(0, 2));
    drain();
    // reset while waiting on the core
    for (int r = 0; r < WIN; r++) send_row(8'h90 + r * 16, r == 0, 0);
    chk("pre_rst_start", start, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    p0 = n_pulses;
    @(negedge clk);
    chk("post_rst_ready", pix_ready, 1);
    chk("post_rst_col", col_index, 0);
    repeat (20) @(posedge clk);
    #1;
    chk("post_rst_no_disp", n_pulses - p0, 0);
    chk("end_starts_empty", sq_col.size(), 0);
    chk("end_results_empty", rq_disp.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
